// File: rtl/spi_apb_pkg.sv
// Shared constants for the SPI APB sequencer: register map,
// status bit positions and sequencer state encodings.
package spi_apb_pkg;

    localparam logic [2:0] ADDR_CR1 = 3'd0;
    localparam logic [2:0] ADDR_CR2 = 3'd1;
    localparam logic [2:0] ADDR_BR  = 3'd2;
    localparam logic [2:0] ADDR_SR  = 3'd3;
    localparam logic [2:0] ADDR_DR  = 3'd5;

    localparam int SR_SPIF  = 7;
    localparam int SR_SPTEF = 5;
    localparam int SR_MODF  = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_CR1,
        ST_WR_CR2,
        ST_WR_BR,
        ST_WR_DR,
        ST_POLL_TX,
        ST_POLL_RX,
        ST_RD_DR,
        ST_DONE,
        ST_ERROR
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_GAP,
        PH_SETUP,
        PH_ACCESS
    } apb_ph_t;

endpackage

// File: rtl/spi_seq_fifo.sv
// Small synchronous byte FIFO holding the TX stream.
// Push is refused when full; push and pop may coincide.
module spi_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         PCLK,
    input  logic         PRESET_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_push;
    logic         w_pop;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                     (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd[AW-1:0]];

    // Storage array; contents are don't-care until written
    always_ff @(posedge PCLK) begin
        if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= i_data;
        end
    end

    // Read/write pointers with an extra wrap bit for full detection
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_apb_sequencer.sv
// APB master that configures the SPI slave, then streams TX bytes
// and reads back RX bytes. Optional SR poll timeout: SPI_SEQ_TIMEOUT_EN.
module spi_apb_sequencer
    import spi_apb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int POLL_LIMIT = 255
) (
    input  logic       PCLK,
    input  logic       PRESET_n,
    input  logic       start_i,
    input  logic [7:0] cfg_cr1_i,
    input  logic [7:0] cfg_cr2_i,
    input  logic [7:0] cfg_br_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       PSEL_o,
    output logic       PENABLE_o,
    output logic       PWRITE_o,
    output logic [2:0] PADDR_o,
    output logic [7:0] PWDATA_o,
    input  logic [7:0] PRDATA_i,
    input  logic       PREADY_i,
    input  logic       PSLVERR_i
);

    seq_state_t r_state;
    apb_ph_t    r_ph;
    logic       r_psel;
    logic       r_penable;
    logic       r_pwrite;
    logic [2:0] r_paddr;
    logic [7:0] r_pwdata;
    logic       r_rx_valid;
    logic [7:0] r_rx_data;
    logic       r_done;
    logic       r_err;

    logic       w_full;
    logic       w_empty;
    logic [7:0] w_head;
    logic       w_pop;
    logic       w_xfer;
    logic       w_fin;
    logic       w_is_sr;
    logic       w_hit;
    logic       w_fail;
    logic       w_timeout;
    logic [2:0] w_addr;
    logic       w_write;
    logic [7:0] w_wdata;

    spi_seq_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .PCLK     (PCLK),
        .PRESET_n (PRESET_n),
        .i_push   (tx_valid_i),
        .i_data   (tx_data_i),
        .i_pop    (w_pop),
        .o_data   (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign tx_ready_o = !w_full;
    assign busy_o     = (r_state != ST_IDLE);
    assign rx_valid_o = r_rx_valid;
    assign rx_data_o  = r_rx_data;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign PSEL_o     = r_psel;
    assign PENABLE_o  = r_penable;
    assign PWRITE_o   = r_pwrite;
    assign PADDR_o    = r_paddr;
    assign PWDATA_o   = r_pwdata;

    assign w_xfer  = (r_state inside {ST_WR_CR1, ST_WR_CR2, ST_WR_BR,
                      ST_WR_DR, ST_POLL_TX, ST_POLL_RX, ST_RD_DR});
    assign w_fin   = (r_ph == PH_ACCESS) && PREADY_i;
    assign w_is_sr = (r_state == ST_POLL_TX) || (r_state == ST_POLL_RX);
    assign w_hit   = (r_state == ST_POLL_TX) ? PRDATA_i[SR_SPTEF]
                                             : PRDATA_i[SR_SPIF];
    assign w_fail  = PSLVERR_i || (w_is_sr && PRDATA_i[SR_MODF]);
    // A DR byte leaves the buffer only once its write is accepted
    assign w_pop   = w_fin && !w_fail && (r_state == ST_WR_DR);

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int PW = $clog2(POLL_LIMIT + 1);

    logic [PW-1:0] r_poll_cnt;

    assign w_timeout = (r_poll_cnt == PW'(POLL_LIMIT - 1));

    // Per-phase count of SR reads that lacked the awaited bit
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_poll_cnt <= '0;
        end else if (w_fin && !w_fail) begin
            if (r_state == ST_WR_DR ||
                (r_state == ST_POLL_TX && w_hit)) begin
                r_poll_cnt <= '0;
            end else if (w_is_sr && !w_hit) begin
                r_poll_cnt <= r_poll_cnt + 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Address, direction and write data for the current state
    always_comb begin
        w_addr  = ADDR_SR;
        w_write = 1'b0;
        w_wdata = 8'h00;
        unique case (r_state)
            ST_WR_CR1: begin
                w_addr  = ADDR_CR1;
                w_write = 1'b1;
                w_wdata = cfg_cr1_i;
            end
            ST_WR_CR2: begin
                w_addr  = ADDR_CR2;
                w_write = 1'b1;
                w_wdata = cfg_cr2_i;
            end
            ST_WR_BR: begin
                w_addr  = ADDR_BR;
                w_write = 1'b1;
                w_wdata = cfg_br_i;
            end
            ST_WR_DR: begin
                w_addr  = ADDR_DR;
                w_write = 1'b1;
                w_wdata = w_head;
            end
            ST_RD_DR: begin
                w_addr = ADDR_DR;
            end
            default: ;
        endcase
    end

    // Sequencer FSM and APB phase engine with registered outputs
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_state    <= ST_IDLE;
            r_ph       <= PH_GAP;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= 3'd0;
            r_pwdata   <= 8'h00;
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;

            // GAP keeps PSEL low for one cycle before each new setup
            unique case (r_ph)
                PH_GAP: begin
                    if (w_xfer) begin
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_paddr   <= w_addr;
                        r_pwrite  <= w_write;
                        r_pwdata  <= w_wdata;
                        r_ph      <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    r_penable <= 1'b1;
                    r_ph      <= PH_ACCESS;
                end
                PH_ACCESS: begin
                    if (PREADY_i) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_ph      <= PH_GAP;
                    end
                end
                default: r_ph <= PH_GAP;
            endcase

            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= ST_WR_CR1;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    if (w_fin) begin
                        if (w_fail) begin
                            r_state <= ST_ERROR;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            unique case (r_state)
                                ST_WR_CR1: r_state <= ST_WR_CR2;
                                ST_WR_CR2: r_state <= ST_WR_BR;
                                ST_WR_DR:  r_state <= ST_POLL_TX;
                                ST_POLL_TX, ST_POLL_RX: begin
                                    if (w_hit) begin
                                        r_state <= (r_state == ST_POLL_TX)
                                                   ? ST_POLL_RX : ST_RD_DR;
                                    end else if (w_timeout) begin
                                        r_state <= ST_ERROR;
                                        r_done  <= 1'b1;
                                        r_err   <= 1'b1;
                                    end
                                end
                                default: begin
                                    if (r_state == ST_RD_DR) begin
                                        r_rx_valid <= 1'b1;
                                        r_rx_data  <= PRDATA_i;
                                    end
                                    r_state <= w_empty ? ST_DONE : ST_WR_DR;
                                    r_done  <= w_empty;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
